timer_expiry_tracker: RTL

- Consumer end of the free-running ns timer.
- Takes the timer's tick strobe (flag) and ns count (counter_ns[15:0]) and runs NSLOT independent down-counting timeouts, for example MAC-table aging or pause-frame timeouts.
- Clients arm or cancel slots by ID.
- When a slot expires, the block queues an expiry event and presents it on a valid/ready output carrying the slot ID and the ns timestamp at expiry.

---
 rtl/timer_pkg.sv | 19 +
 rtl/timer_slot.sv | 72 +++++++
 rtl/timer_expiry_tracker.sv | 97 +++++++++
 3 files changed

// File: rtl/timer_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Package     : timer_pkg                                              |
// | Description : Shared widths and slot-state encoding for the timer    |
// |               expiry tracker.                                        |
// | Revision    : 1.0 - initial release                                  |
// +----------------------------------------------------------------------+
package timer_pkg;

    localparam int TS_W = 16;

    typedef enum logic [1:0] {
        SLOT_IDLE  = 2'd0,
        SLOT_COUNT = 2'd1,
        SLOT_PEND  = 2'd2
    } slot_state_t;

endpackage
`default_nettype wire

// File: rtl/timer_slot.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : timer_slot                                             |
// | Description : One down-counting timeout slot with expiry timestamp.  |
// | Revision    : 1.0 - initial release                                  |
// +----------------------------------------------------------------------+
module timer_slot
    import timer_pkg::*;
#(
    parameter int TW = 12
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            i_tick,
    input  logic [TS_W-1:0] i_counter_ns,
    input  logic            i_arm,
    input  logic [TW-1:0]   i_arm_timeout,
    input  logic            i_cancel,
    input  logic            i_load,
    output logic            o_active,
    output logic            o_pending,
    output logic [TS_W-1:0] o_ts
);

    slot_state_t     r_state;
    logic [TW-1:0]   r_remaining;
    logic [TS_W-1:0] r_ts;

    // Arm beats cancel beats tick; an arm also overrides a same-cycle load,
    // the previously pending event having already been copied out.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= SLOT_IDLE;
            r_remaining <= '0;
            r_ts        <= '0;
        end else if (i_arm) begin
            if (i_arm_timeout != '0) begin
                r_state     <= SLOT_COUNT;
                r_remaining <= i_arm_timeout;
            end else begin
                r_state     <= SLOT_PEND;
                r_remaining <= '0;
                r_ts        <= i_counter_ns;
            end
        end else if (i_cancel) begin
            if (r_state != SLOT_IDLE) begin
                r_state     <= SLOT_IDLE;
                r_remaining <= '0;
            end
        end else if (r_state == SLOT_COUNT) begin
            if (i_tick) begin
                if (r_remaining == TW'(1)) begin
                    r_state     <= SLOT_PEND;
                    r_remaining <= '0;
                    r_ts        <= i_counter_ns;
                end else begin
                    r_remaining <= r_remaining - TW'(1);
                end
            end
        end else if (r_state == SLOT_PEND) begin
            if (i_load) begin
                r_state <= SLOT_IDLE;
            end
        end
    end

    assign o_active  = (r_state == SLOT_COUNT);
    assign o_pending = (r_state == SLOT_PEND);
    assign o_ts      = r_ts;

endmodule
`default_nettype wire

// File: rtl/timer_expiry_tracker.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : timer_expiry_tracker                                   |
// | Description : NSLOT tick-driven timeouts with a valid/ready expiry   |
// |               event output (slot ID + ns timestamp).                 |
// | Revision    : 1.0 - initial release                                  |
// +----------------------------------------------------------------------+
module timer_expiry_tracker
    import timer_pkg::*;
#(
    parameter int NSLOT = 8,
    parameter int IDW   = 3,
    parameter int TW    = 12
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             tick,
    input  logic [15:0]      counter_ns,
    input  logic             arm_valid,
    input  logic [IDW-1:0]   arm_id,
    input  logic [TW-1:0]    arm_timeout,
    input  logic             cancel_valid,
    input  logic [IDW-1:0]   cancel_id,
    output logic [NSLOT-1:0] active,
    output logic             expire_valid,
    input  logic             expire_ready,
    output logic [IDW-1:0]   expire_id,
    output logic [15:0]      expire_ts
);

    logic [NSLOT-1:0] w_active;
    logic [NSLOT-1:0] w_pending;
    logic [NSLOT-1:0] w_load_vec;
    logic [TS_W-1:0]  w_slot_ts [NSLOT];
    logic [IDW-1:0]   w_sel_id;
    logic             w_load_en;

    logic             r_valid;
    logic [IDW-1:0]   r_id;
    logic [TS_W-1:0]  r_ts;

    generate
        for (genvar g = 0; g < NSLOT; g++) begin : g_slot
            timer_slot #(
                .TW (TW)
            ) u_slot (
                .clk           (clk),
                .rst           (rst),
                .i_tick        (tick),
                .i_counter_ns  (counter_ns),
                .i_arm         (arm_valid && (arm_id == IDW'(g))),
                .i_arm_timeout (arm_timeout),
                .i_cancel      (cancel_valid && (cancel_id == IDW'(g))),
                .i_load        (w_load_vec[g]),
                .o_active      (w_active[g]),
                .o_pending     (w_pending[g]),
                .o_ts          (w_slot_ts[g])
            );
        end
    endgenerate

    // Descending scan so the lowest pending index is the one left standing.
    always_comb begin
        w_sel_id   = '0;
        w_load_vec = '0;
        for (int i = NSLOT - 1; i >= 0; i--) begin
            if (w_pending[i]) begin
                w_sel_id = IDW'(i);
            end
        end
        w_load_en = (|w_pending) && (!r_valid || expire_ready);
        if (w_load_en) begin
            w_load_vec[w_sel_id] = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_valid <= 1'b0;
            r_id    <= '0;
            r_ts    <= '0;
        end else if (w_load_en) begin
            r_valid <= 1'b1;
            r_id    <= w_sel_id;
            r_ts    <= w_slot_ts[w_sel_id];
        end else if (expire_ready) begin
            r_valid <= 1'b0;
        end
    end

    assign active       = w_active;
    assign expire_valid = r_valid;
    assign expire_id    = r_id;
    assign expire_ts    = r_ts;

endmodule
`default_nettype wire
